// File: rtl/sa_os_mm.sv
// Output-stationary systolic matmul: C = A*B with skewed operand feed, valid-tagged bubbles and row-serial drain.
// Build option SA_ROUND_EN: round-half-up on drain instead of floor truncation.
module sa_os_mm_pe #(
  parameter int D_W   = 16,
  parameter int ACC_W = 40
) (
  input  logic                    gclk,
  input  logic                    grst_n,
  input  logic                    clr,
  input  logic                    v_in,
  input  logic [D_W-1:0]          x_in,
  input  logic [D_W-1:0]          w_in,
  output logic                    v_out,
  output logic [D_W-1:0]          x_out,
  output logic [D_W-1:0]          w_out,
  output logic signed [ACC_W-1:0] acc
);
  logic signed [2*D_W-1:0] prod;
  assign prod = $signed(x_in) * $signed(w_in);

  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n) begin
      v_out <= 1'b0;
      x_out <= '0;
      w_out <= '0;
      acc   <= '0;
    end else begin
      v_out <= v_in;
      x_out <= x_in;
      w_out <= w_in;
      if (clr)       acc <= '0;
      else if (v_in) acc <= acc + {{(ACC_W-2*D_W){prod[2*D_W-1]}}, prod};
    end
endmodule

module sa_os_mm #(
  parameter int D_W   = 16,
  parameter int FRAC  = 13,
  parameter int SA_R  = 16,
  parameter int SA_C  = 16,
  parameter int K_MAX = 256
) (
  input  logic                              I_CLK,
  input  logic                              I_ASYN_RSTN,
  input  logic                              I_START,
  input  logic [$clog2(K_MAX):0]            I_K_LEN,
  input  logic                              I_VLD,
  output logic                              O_RDY,
  input  logic [SA_R-1:0][D_W-1:0]          I_X,
  input  logic [SA_C-1:0][D_W-1:0]          I_W,
  output logic                              O_BUSY,
  output logic                              O_ROW_VLD,
  input  logic                              I_ROW_RDY,
  output logic [$clog2(SA_R)-1:0]           O_ROW_IDX,
  output logic [SA_C-1:0][D_W-1:0]          O_ROW,
  output logic                              O_DONE
);
  localparam int ACC_W = 2*D_W + $clog2(K_MAX);
  localparam int KW    = $clog2(K_MAX) + 1;
  localparam int RW    = $clog2(SA_R);
  localparam int FL_N  = SA_R + SA_C - 1;
  localparam int FW    = $clog2(FL_N + 1);
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((2**(D_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = -SMAX - 1;
  localparam logic signed [ACC_W-1:0] RND  = ACC_W'(2**(FRAC-1));

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} st_t;
  st_t st, nxt;

  logic [KW-1:0] k_len, beat_cnt;
  logic [FW-1:0] fl_cnt;
  logic [RW-1:0] row_idx;
  logic          done, acc_clr, beat, row_acc;

  assign O_RDY     = (st == LOAD);
  assign O_BUSY    = (st != IDLE);
  assign O_ROW_VLD = (st == DRAIN);
  assign O_ROW_IDX = row_idx;
  assign O_DONE    = done;
  assign beat      = O_RDY & I_VLD;
  assign row_acc   = O_ROW_VLD & I_ROW_RDY;

  always_comb begin
    nxt     = st;
    acc_clr = 1'b0;
    case (st)
      IDLE:  if (I_START) begin
               acc_clr = 1'b1;
               nxt     = (I_K_LEN == '0) ? DRAIN : LOAD;
             end
      LOAD:  if (beat && (beat_cnt + KW'(1) == k_len)) nxt = FLUSH;
      FLUSH: if (fl_cnt == FW'(FL_N - 1)) nxt = DRAIN;
      DRAIN: if (row_acc && row_idx == RW'(SA_R - 1)) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN)
    if (!I_ASYN_RSTN) begin
      st       <= IDLE;
      k_len    <= '0;
      beat_cnt <= '0;
      fl_cnt   <= '0;
      row_idx  <= '0;
      done     <= 1'b0;
    end else begin
      st   <= nxt;
      done <= (st == DRAIN) && (nxt == IDLE);
      if (acc_clr) begin
        k_len    <= I_K_LEN;
        beat_cnt <= '0;
        fl_cnt   <= '0;
        row_idx  <= '0;
      end
      if (beat)        beat_cnt <= beat_cnt + KW'(1);
      if (st == FLUSH) fl_cnt   <= fl_cnt + FW'(1);
      if (row_acc)     row_idx  <= (row_idx == RW'(SA_R - 1)) ? '0 : row_idx + RW'(1);
    end

  // One input register stage lines up the last product with the final FLUSH cycle.
  logic [SA_R-1:0][D_W-1:0] x_q;
  logic [SA_C-1:0][D_W-1:0] w_q;
  logic                     v_q;

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN)
    if (!I_ASYN_RSTN) begin
      x_q <= '0;
      w_q <= '0;
      v_q <= 1'b0;
    end else begin
      x_q <= I_X;
      w_q <= I_W;
      v_q <= beat;
    end

  // Skewed lanes; the valid tag rides with x, which meets w in every PE at the same beat.
  logic [D_W:0]   xv_sk [SA_R];
  logic [D_W-1:0] w_sk  [SA_C];

  for (genvar i = 0; i < SA_R; i++) begin : g_xsk
    if (i == 0) begin : g_pass
      assign xv_sk[i] = {v_q, x_q[i]};
    end else begin : g_dly
      logic [D_W:0] sr [1:i];
      always_ff @(posedge I_CLK or negedge I_ASYN_RSTN)
        if (!I_ASYN_RSTN) for (int d = 1; d <= i; d++) sr[d] <= '0;
        else begin
          sr[1] <= {v_q, x_q[i]};
          for (int d = 2; d <= i; d++) sr[d] <= sr[d-1];
        end
      assign xv_sk[i] = sr[i];
    end
  end

  for (genvar j = 0; j < SA_C; j++) begin : g_wsk
    if (j == 0) begin : g_pass
      assign w_sk[j] = w_q[j];
    end else begin : g_dly
      logic [D_W-1:0] sr [1:j];
      always_ff @(posedge I_CLK or negedge I_ASYN_RSTN)
        if (!I_ASYN_RSTN) for (int d = 1; d <= j; d++) sr[d] <= '0;
        else begin
          sr[1] <= w_q[j];
          for (int d = 2; d <= j; d++) sr[d] <= sr[d-1];
        end
      assign w_sk[j] = sr[j];
    end
  end

  logic                    vo  [SA_R][SA_C];
  logic [D_W-1:0]          xo  [SA_R][SA_C];
  logic [D_W-1:0]          wo  [SA_R][SA_C];
  logic signed [ACC_W-1:0] acc [SA_R][SA_C];

  for (genvar i = 0; i < SA_R; i++) begin : g_row
    for (genvar j = 0; j < SA_C; j++) begin : g_col
      logic           pv;
      logic [D_W-1:0] px, pw;
      if (j == 0) begin : g_xl
        assign pv = xv_sk[i][D_W];
        assign px = xv_sk[i][D_W-1:0];
      end else begin : g_xi
        assign pv = vo[i][j-1];
        assign px = xo[i][j-1];
      end
      if (i == 0) begin : g_wt
        assign pw = w_sk[j];
      end else begin : g_wi
        assign pw = wo[i-1][j];
      end
      sa_os_mm_pe #(.D_W(D_W), .ACC_W(ACC_W)) u_pe (
        .gclk(I_CLK), .grst_n(I_ASYN_RSTN), .clr(acc_clr),
        .v_in(pv), .x_in(px), .w_in(pw),
        .v_out(vo[i][j]), .x_out(xo[i][j]), .w_out(wo[i][j]), .acc(acc[i][j])
      );
    end
  end

  function automatic logic [D_W-1:0] sat_fn(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
`ifdef SA_ROUND_EN
    s = (a + RND) >>> FRAC;
`else
    s = a >>> FRAC;
`endif
    if (s > SMAX)      return SMAX[D_W-1:0];
    else if (s < SMIN) return SMIN[D_W-1:0];
    else               return s[D_W-1:0];
  endfunction

  always_comb
    for (int j = 0; j < SA_C; j++) O_ROW[j] = sat_fn(acc[row_idx][j]);
endmodule
